// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the response-slave state encoding.
// Imported by the response slave and its testbench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2,
    StDone
  } resp_state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a free OKAY.
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_err_log.sv
// Error log for the response slave: saturating counter, last-error address and
// direction capture, and a sticky interrupt with set-over-clear priority.
module ahb_err_log #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  capture,
  input  logic [ADDR_WIDTH-1:0] cap_addr,
  input  logic                  cap_write,
  input  logic                  inc,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic                  err_irq
);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  irq_q, irq_d;

  always_comb begin
    count_d = count_q;
    irq_d   = irq_q;
    addr_d  = addr_q;
    write_d = write_q;
    if (inc) begin
      // A new error outranks a clear in the same cycle.
      if (clr) begin
        count_d = CNT_WIDTH'(1);
      end else if (!(&count_q)) begin
        count_d = count_q + CNT_WIDTH'(1);
      end
      irq_d = 1'b1;
    end else if (clr) begin
      count_d = '0;
      irq_d   = 1'b0;
    end
    if (capture) begin
      addr_d  = cap_addr;
      write_d = cap_write;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      irq_q   <= irq_d;
    end
  end

  assign err_count = count_q;
  assign err_addr  = addr_q;
  assign err_write = write_q;
  assign err_irq   = irq_q;

endmodule

// File: rtl/ahb_resp_slave.sv
// AHB-Lite default/terminator slave: two-cycle ERROR (MODE 0) or OKAY sink (MODE 1),
// with optional wait states and an error log for software/debug.
module ahb_resp_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MODE        = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYin,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADYout,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic                  err_irq
);

  localparam int unsigned WsW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WsW-1:0] WsLoad = (WAIT_STATES > 0) ? WsW'(WAIT_STATES - 1) : '0;
  localparam bit ErrMode = (MODE == 0);

  resp_state_e    state_q, state_d;
  logic [WsW-1:0] ws_q, ws_d;
  logic           hready_q, hready_d;
  logic [1:0]     hresp_q, hresp_d;
  logic           acc;
  logic           can_accept;
  logic           log_capture;
  logic           log_inc;

  assign acc = HSEL & HREADYin & trans_active(HTRANS);

  // WAIT and ERR1 hold HREADY low, so a new transfer can only start elsewhere.
  assign can_accept = (state_q == StIdle) || (state_q == StErr2) || (state_q == StDone);

  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    unique case (state_q)
      StIdle, StErr2, StDone: begin
        state_d = StIdle;
        if (acc) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            ws_d    = WsLoad;
          end else if (ErrMode) begin
            state_d = StErr1;
          end
        end
      end
      StWait: begin
        if (ws_q == '0) begin
          state_d = ErrMode ? StErr1 : StDone;
        end else begin
          ws_d = ws_q - WsW'(1);
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they leave the flops glitch-free.
  always_comb begin
    hready_d = 1'b1;
    hresp_d  = HRESP_OKAY;
    unique case (state_d)
      StWait: hready_d = 1'b0;
      StErr1: begin
        hready_d = 1'b0;
        hresp_d  = HRESP_ERROR;
      end
      StErr2:  hresp_d = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      ws_q     <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      ws_q     <= ws_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign HREADYout = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = '0;

  assign log_capture = ErrMode && acc && can_accept;
  assign log_inc     = ErrMode && (state_d == StErr1) && (state_q != StErr1);

  ahb_err_log #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_err_log (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .capture  (log_capture),
    .cap_addr (HADDR),
    .cap_write(HWRITE),
    .inc      (log_inc),
    .clr      (err_clr),
    .err_count(err_count),
    .err_addr (err_addr),
    .err_write(err_write),
    .err_irq  (err_irq)
  );

  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HBURST, HWDATA};

endmodule

// File: tb/tb_ahb_resp_slave.sv
// Scoreboard bench for ahb_resp_slave: six instances cover the MODE/WAIT_STATES/CNT_WIDTH
// corners; expectations are queued per cycle at issue time and checked by a monitor.
module tb_ahb_resp_slave;
  import ahb_pkg::*;

  localparam int N = 6;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [N-1:0] sel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        err_clr;
  logic        nr_force;

  logic [N-1:0]       rdy_v, hrin_v, wr_v, irq_v;
  logic [N-1:0][1:0]  resp_v;
  logic [N-1:0][31:0] rdata_v, addr_v;
  logic [N-1:0][7:0]  cnt_v;

  always #5 HCLK = ~HCLK;

  // 0: ERR ws0 | 1: ERR ws3 | 2: OKAY ws0 | 3: ERR ws0 cnt2 | 4: ERR ws2 | 5: OKAY ws2
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned GMode = (g == 2 || g == 5) ? 1 : 0;
    localparam int unsigned GWs   = (g == 1) ? 3 : ((g == 4 || g == 5) ? 2 : 0);
    localparam int unsigned GCw   = (g == 3) ? 2 : 8;
    logic [GCw-1:0] cnt_w;

    assign hrin_v[g] = rdy_v[g] & ~nr_force;
    assign cnt_v[g]  = 8'(cnt_w);

    ahb_resp_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MODE       (GMode),
      .WAIT_STATES(GWs),
      .CNT_WIDTH  (GCw)
    ) u_dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (sel[g]),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HWDATA   (HWDATA),
      .HREADYin (hrin_v[g]),
      .HRDATA   (rdata_v[g]),
      .HRESP    (resp_v[g]),
      .HREADYout(rdy_v[g]),
      .err_clr  (err_clr),
      .err_count(cnt_w),
      .err_addr (addr_v[g]),
      .err_write(wr_v[g]),
      .err_irq  (irq_v[g])
    );
  end

  typedef struct {
    int          dut;
    int          cyc;
    int          tst;
    bit          is_log;
    logic        rdy;
    logic [1:0]  resp;
    logic [7:0]  cnt;
    logic [31:0] addr;
    logic        wr;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base;
  int   checks = 0;
  int   errors = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic push(input exp_t e);
    int pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic exp_rsp(input int k, input int off, input logic rdy, input logic [1:0] rsp,
                         input int t);
    exp_t e;
    e = '{dut: k, cyc: base + off, tst: t, is_log: 1'b0, rdy: rdy, resp: rsp,
          cnt: 8'd0, addr: 32'd0, wr: 1'b0, irq: 1'b0};
    push(e);
  endtask

  task automatic exp_log(input int k, input int off, input logic [7:0] c, input logic [31:0] a,
                         input logic w, input logic irq, input int t);
    exp_t e;
    e = '{dut: k, cyc: base + off, tst: t, is_log: 1'b1, rdy: 1'b0, resp: 2'b00,
          cnt: c, addr: a, wr: w, irq: irq};
    push(e);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input int k, input logic [1:0] tr, input logic [31:0] a, input logic w);
    sel = '0;
    if (k >= 0) sel[k] = 1'b1;
    HTRANS = tr;
    HADDR  = a;
    HWRITE = w;
  endtask

  exp_t me;
  always @(negedge HCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      checks++;
      if (me.cyc != cyc) begin
        errors++;
        $display("FAIL stale t%0d dut%0d: due cyc %0d, monitor at cyc %0d",
                 me.tst, me.dut, me.cyc, cyc);
      end else if (me.is_log) begin
        if (cnt_v[me.dut] !== me.cnt || addr_v[me.dut] !== me.addr ||
            wr_v[me.dut] !== me.wr || irq_v[me.dut] !== me.irq) begin
          errors++;
          $display("FAIL log t%0d dut%0d cyc%0d: got cnt=%0d addr=%h wr=%b irq=%b, want cnt=%0d addr=%h wr=%b irq=%b",
                   me.tst, me.dut, cyc, cnt_v[me.dut], addr_v[me.dut], wr_v[me.dut],
                   irq_v[me.dut], me.cnt, me.addr, me.wr, me.irq);
        end
      end else begin
        if (rdy_v[me.dut] !== me.rdy || resp_v[me.dut] !== me.resp ||
            rdata_v[me.dut] !== 32'd0) begin
          errors++;
          $display("FAIL resp t%0d dut%0d cyc%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=0",
                   me.tst, me.dut, cyc, rdy_v[me.dut], resp_v[me.dut], rdata_v[me.dut],
                   me.rdy, me.resp);
        end
      end
    end
  end

  initial begin
    HRESETn  = 1'b0;
    sel      = '0;
    HADDR    = '0;
    HTRANS   = HTRANS_IDLE;
    HWRITE   = 1'b0;
    HSIZE    = 3'd2;
    HBURST   = 3'd0;
    HWDATA   = 32'hDEAD_BEEF;
    err_clr  = 1'b0;
    nr_force = 1'b0;

    // Reset state of every instance, during and just after reset.
    tick();
    tick();
    base = cyc;
    for (int k = 0; k < N; k++) begin
      exp_rsp(k, 0, 1'b1, HRESP_OKAY, 0);
      exp_log(k, 2, 8'd0, 32'd0, 1'b0, 1'b0, 0);
      exp_rsp(k, 2, 1'b1, HRESP_OKAY, 0);
    end
    tick();
    HRESETn = 1'b1;
    tick();
    tick();

    // 1: MODE 0, WS 0 read error.
    base = cyc;
    drv(0, HTRANS_NONSEQ, 32'h4000_0010, 1'b0);
    exp_rsp(0, 1, 1'b0, HRESP_ERROR, 1);
    exp_rsp(0, 2, 1'b1, HRESP_ERROR, 1);
    exp_rsp(0, 3, 1'b1, HRESP_OKAY, 1);
    exp_log(0, 2, 8'd1, 32'h4000_0010, 1'b0, 1'b1, 1);
    tick();
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    repeat (3) tick();

    // 2: MODE 0, WS 3 write error.
    base = cyc;
    drv(1, HTRANS_NONSEQ, 32'h4000_0100, 1'b1);
    for (int i = 1; i <= 3; i++) exp_rsp(1, i, 1'b0, HRESP_OKAY, 2);
    exp_rsp(1, 4, 1'b0, HRESP_ERROR, 2);
    exp_rsp(1, 5, 1'b1, HRESP_ERROR, 2);
    exp_rsp(1, 6, 1'b1, HRESP_OKAY, 2);
    exp_log(1, 1, 8'd0, 32'h4000_0100, 1'b1, 1'b0, 2);
    exp_log(1, 5, 8'd1, 32'h4000_0100, 1'b1, 1'b1, 2);
    tick();
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    repeat (7) tick();

    // 3: MODE 1, WS 0 INCR4 burst, zero-wait OKAY every beat.
    base = cyc;
    HBURST = 3'b011;
    for (int i = 0; i < 4; i++) begin
      drv(2, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0000_0100 + 32'(4 * i), 1'b0);
      exp_rsp(2, i + 1, 1'b1, HRESP_OKAY, 3);
      tick();
    end
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    HBURST = 3'b000;
    exp_log(2, 5, 8'd0, 32'd0, 1'b0, 1'b0, 3);
    repeat (3) tick();

    // 3b: MODE 1, WS 2 write: wait, wait, DONE, nothing logged.
    base = cyc;
    drv(5, HTRANS_NONSEQ, 32'h0000_0200, 1'b1);
    exp_rsp(5, 1, 1'b0, HRESP_OKAY, 31);
    exp_rsp(5, 2, 1'b0, HRESP_OKAY, 31);
    exp_rsp(5, 3, 1'b1, HRESP_OKAY, 31);
    exp_rsp(5, 4, 1'b1, HRESP_OKAY, 31);
    exp_log(5, 4, 8'd0, 32'd0, 1'b0, 1'b0, 31);
    tick();
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    repeat (5) tick();

    // 5: IDLE/BUSY while selected, then NONSEQ with HREADYin low: all ignored.
    base = cyc;
    drv(0, HTRANS_IDLE, 32'h5000_0000, 1'b1);
    exp_rsp(0, 1, 1'b1, HRESP_OKAY, 5);
    tick();
    drv(0, HTRANS_BUSY, 32'h5000_0004, 1'b1);
    exp_rsp(0, 2, 1'b1, HRESP_OKAY, 5);
    tick();
    nr_force = 1'b1;
    drv(0, HTRANS_NONSEQ, 32'h6000_0000, 1'b1);
    exp_rsp(0, 3, 1'b1, HRESP_OKAY, 5);
    exp_rsp(0, 4, 1'b1, HRESP_OKAY, 5);
    exp_log(0, 4, 8'd1, 32'h4000_0010, 1'b0, 1'b1, 5);
    tick();
    nr_force = 1'b0;
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    repeat (3) tick();

    // 4: CNT_WIDTH 2, back-to-back errors via ERR2, saturation, then clear priority.
    base = cyc;
    for (int i = 0; i < 6; i++) begin
      drv(3, HTRANS_NONSEQ, 32'h4000_1000 + 32'(4 * i), i[0]);
      if (i == 5) err_clr = 1'b1;
      exp_rsp(3, 2 * i + 1, 1'b0, HRESP_ERROR, 4);
      exp_rsp(3, 2 * i + 2, 1'b1, HRESP_ERROR, 4);
      exp_log(3, 2 * i + 2, (i < 5) ? 8'((i + 1 > 3) ? 3 : i + 1) : 8'd1,
              32'h4000_1000 + 32'(4 * i), i[0], 1'b1, 4);
      tick();
      err_clr = 1'b0;
      drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
      tick();
    end
    tick();
    err_clr = 1'b1;
    exp_rsp(3, 13, 1'b1, HRESP_OKAY, 4);
    exp_log(3, 13, 8'd1, 32'h4000_1014, 1'b1, 1'b1, 4);
    exp_log(3, 14, 8'd0, 32'h4000_1014, 1'b1, 1'b0, 4);
    tick();
    err_clr = 1'b0;
    repeat (3) tick();

    // 6: MODE 0, WS 2, async reset while in ERR1, then a normal transfer.
    base = cyc;
    drv(4, HTRANS_NONSEQ, 32'h7000_0000, 1'b1);
    exp_rsp(4, 1, 1'b0, HRESP_OKAY, 6);
    exp_rsp(4, 2, 1'b0, HRESP_OKAY, 6);
    exp_log(4, 2, 8'd0, 32'h7000_0000, 1'b1, 1'b0, 6);
    exp_rsp(4, 3, 1'b1, HRESP_OKAY, 6);
    exp_log(4, 3, 8'd0, 32'd0, 1'b0, 1'b0, 6);
    exp_rsp(4, 4, 1'b1, HRESP_OKAY, 6);
    tick();
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);
    tick();
    tick();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    base = cyc;
    drv(4, HTRANS_NONSEQ, 32'h7000_0040, 1'b0);
    exp_rsp(4, 1, 1'b0, HRESP_OKAY, 6);
    exp_rsp(4, 2, 1'b0, HRESP_OKAY, 6);
    exp_rsp(4, 3, 1'b0, HRESP_ERROR, 6);
    exp_rsp(4, 4, 1'b1, HRESP_ERROR, 6);
    exp_rsp(4, 5, 1'b1, HRESP_OKAY, 6);
    exp_log(4, 4, 8'd1, 32'h7000_0040, 1'b0, 1'b1, 6);
    tick();
    drv(-1, HTRANS_IDLE, 32'h0, 1'b0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
